// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and round functions.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // a occupies the top word so a packed hash maps straight onto the digest port.
    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } hash_t;

    // Index 15 holds W[t], index 0 the newest word, so M_in loads without reordering.
    typedef logic [15:0][31:0] win_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam hash_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t Ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t Maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t S0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t S1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic hash_t hash_add(input hash_t x, input hash_t y);
        return '{a: x.a + y.a, b: x.b + y.b, c: x.c + y.c, d: x.d + y.d,
                 e: x.e + y.e, f: x.f + y.f, g: x.g + y.g, h: x.h + y.h};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round plus one step of the rolling message schedule.
// Zero latency, no flow control; chained RPC deep inside the core.
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t st_i,
    input  win_t  win_i,
    input  word_t k_i,
    output hash_t st_o,
    output win_t  win_o
);

    word_t t1, t2, w_new;

    assign t1    = st_i.h + S1(st_i.e) + Ch(st_i.e, st_i.f, st_i.g) + k_i + win_i[15];
    assign t2    = S0(st_i.a) + Maj(st_i.a, st_i.b, st_i.c);
    assign st_o  = '{a: t1 + t2, b: st_i.a, c: st_i.b, d: st_i.c,
                     e: st_i.d + t1, f: st_i.e, g: st_i.f, h: st_i.g};

    // W[t+16] from W[t+14], W[t+9], W[t+1], W[t]; extra words past round 63 are never used.
    assign w_new = s1(win_i[1]) + win_i[6] + s0(win_i[14]) + win_i[15];
    assign win_o = {win_i[14:0], w_new};

endmodule

// File: rtl/sha256_core.sv
// SHA-256 block compressor with optional digest chaining, RPC rounds per clock.
// Digest valid 64/RPC edges after acceptance; holds in DONE until out_rdy, accepts only in IDLE.
module sha256_core
    import sha256_pkg::*;
#(
    parameter int RPC      = 1,
    parameter bit CHAIN_EN = 1'b1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] M_in,
    input  logic         init,
    input  logic         in_v,
    output logic         in_rdy,
    output logic [255:0] H256_out,
    output logic         out_v,
    input  logic         out_rdy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
        $error("sha256_core: RPC must be 1, 2 or 4");
    end

    localparam logic [6:0] RPC_W = 7'(RPC);
    localparam logic [6:0] LAST  = 7'(64 - RPC);

    state_e      state_q, state_d;
    hash_t       base_q, base_d, work_q, work_d, chain_q, chain_d;
    win_t        win_q, win_d;
    logic [6:0]  cnt_q, cnt_d;
    hash_t       base_sel, st_last, sum;
    win_t        win_last;

    for (genvar i = 0; i < RPC; i++) begin : g_round
        hash_t st_in, st_out;
        win_t  win_in, win_out;
        if (i == 0) begin : g_first
            assign st_in  = work_q;
            assign win_in = win_q;
        end else begin : g_next
            assign st_in  = g_round[i-1].st_out;
            assign win_in = g_round[i-1].win_out;
        end
        sha256_round u_round (
            .st_i  (st_in),
            .win_i (win_in),
            .k_i   (K[cnt_q[5:0] + 6'(i)]),
            .st_o  (st_out),
            .win_o (win_out)
        );
    end

    assign st_last  = g_round[RPC-1].st_out;
    assign win_last = g_round[RPC-1].win_out;
    assign base_sel = (init || !CHAIN_EN) ? IV : chain_q;
    assign sum      = hash_add(base_q, work_q);
    assign H256_out = sum;
    assign in_rdy   = (state_q == IDLE);
    assign out_v    = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_v)            state_d = RUN;
            RUN:     if (cnt_q == LAST)   state_d = DONE;
            DONE:    if (out_rdy)         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        base_d  = base_q;
        work_d  = work_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        unique case (state_q)
            IDLE: if (in_v) begin
                base_d = base_sel;
                work_d = base_sel;
                win_d  = M_in;
                cnt_d  = '0;
            end
            RUN: begin
                work_d = st_last;
                win_d  = win_last;
                cnt_d  = (cnt_q >= LAST) ? 7'd64 : cnt_q + RPC_W;
            end
            DONE: if (out_rdy) chain_d = sum;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            work_q  <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            chain_q <= IV;
        end else begin
            base_q  <= base_d;
            work_q  <= work_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
        end
    end

endmodule

// File: tb/tb_sha256_core.sv
// Drives four cores (RPC 1/2/4 chained, RPC 1 unchained) in lockstep against a plain SHA-256 model.
module tb_sha256_core;

    localparam int ND = 4;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] m_in;
    logic         init, in_v, out_rdy;
    logic         in_rdy [ND];
    logic         out_v  [ND];
    logic [255:0] h_out  [ND];
    logic [255:0] chain_m [ND];
    int           n_chk = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sha256_core #(
            .RPC      (g == 1 ? 2 : (g == 2 ? 4 : 1)),
            .CHAIN_EN (g == 3 ? 1'b0 : 1'b1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .M_in     (m_in),
            .init     (init),
            .in_v     (in_v),
            .in_rdy   (in_rdy[g]),
            .H256_out (h_out[g]),
            .out_v    (out_v[g]),
            .out_rdy  (out_rdy)
        );
    end

    function automatic int rpc_of(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 4 : 1);
    endfunction

    function automatic bit chained(input int d);
        return d != 3;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h want=%h", tag, got, want);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook compression: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit all_rdy();
        return in_rdy[0] & in_rdy[1] & in_rdy[2] & in_rdy[3];
    endfunction

    task automatic wait_rdy();
        int waited = 0;
        while (!all_rdy() && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("rdy_before", 256'(all_rdy()), 256'd1);
    endtask

    task automatic send_block(input logic [511:0] blk, input logic ini, input int hold,
                              input bit noise, input logic [255:0] kat, input logic [3:0] kat_en);
        logic [255:0] want [ND];
        logic [255:0] snap [ND];
        int           lat  [ND];
        bit           stable, alld;
        for (int d = 0; d < ND; d++) begin
            want[d] = compress((ini || !chained(d)) ? IV : chain_m[d], blk);
            lat[d]  = 0;
        end
        wait_rdy();
        m_in = blk; init = ini; in_v = 1'b1; out_rdy = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) chk($sformatf("busy%0d", d), 256'(in_rdy[d]), 256'd0);
        in_v = noise;
        alld = 1'b0;
        for (int cyc = 1; cyc <= 80 && !alld; cyc++) begin
            if (noise) begin
                m_in = rand_blk();
                init = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            alld = 1'b1;
            for (int d = 0; d < ND; d++) begin
                if (lat[d] == 0 && out_v[d]) lat[d] = cyc;
                if (lat[d] == 0) alld = 1'b0;
            end
        end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("latency%0d", d), 256'(lat[d]), 256'(64 / rpc_of(d)));
            snap[d] = h_out[d];
        end
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            for (int d = 0; d < ND; d++)
                if (h_out[d] !== snap[d] || !out_v[d] || in_rdy[d]) stable = 1'b0;
        end
        chk("hold_stable", 256'(stable), 256'd1);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("digest%0d", d), h_out[d], want[d]);
            if (kat_en[d]) chk($sformatf("kat%0d", d), h_out[d], kat);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rdy_after%0d", d), 256'(in_rdy[d]), 256'd1);
            chk($sformatf("outv_after%0d", d), 256'(out_v[d]), 256'd0);
            chain_m[d] = want[d];
        end
        in_v = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_v = 1'b0; init = 1'b0; out_rdy = 1'b0; m_in = '0;
        for (int d = 0; d < ND; d++) chain_m[d] = IV;
        #12;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_rdy%0d", d), 256'(in_rdy[d]), 256'd1);
            chk($sformatf("rst_outv%0d", d), 256'(out_v[d]), 256'd0);
        end
        @(negedge clk) rst_n = 1'b1;

        send_block(BLK_ABC, 1'b1, 0, 1'b0, DG_ABC, 4'hF);
        send_block(BLK_EMPTY, 1'b1, 0, 1'b0, DG_EMPTY, 4'hF);
        send_block(BLK_TWO1, 1'b1, 0, 1'b0, '0, 4'h0);
        send_block(BLK_TWO2, 1'b0, 0, 1'b0, DG_TWO, 4'b0111);
        send_block(BLK_ABC, 1'b1, 10, 1'b0, DG_ABC, 4'hF);
        send_block(BLK_ABC, 1'b1, 3, 1'b1, DG_ABC, 4'hF);

        // Abort a chained block at round 30 of the RPC=1 core; the chain must fall back to the IV.
        wait_rdy();
        m_in = rand_blk(); init = 1'b0; in_v = 1'b1;
        @(posedge clk); #1;
        in_v = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("abort_rdy%0d", d), 256'(in_rdy[d]), 256'd1);
            chk($sformatf("abort_outv%0d", d), 256'(out_v[d]), 256'd0);
            chain_m[d] = IV;
        end
        #1 rst_n = 1'b1;
        send_block(BLK_ABC, 1'b0, 2, 1'b0, DG_ABC, 4'hF);

        repeat (6)
            send_block(rand_blk(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), '0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 Parameter RPC, default 1, meaning SHA-256 rounds per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 Parameter CHAIN_EN, default 1, meaning 1 enables multi-block digest chaining and 0 forces every block to start from the IV.
REQ-003 Port clk, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 Port M_in, input, 512, message block; word W0 is [511:480] and W15 is [31:0], big-endian.
REQ-006 Port init, input, 1, sampled with the block; 1 starts a new message from the IV, 0 continues from the previous digest.
REQ-007 Port in_v, input, 1, block valid.
REQ-008 Port in_rdy, output, 1, the core can accept a block.
REQ-009 Port H256_out, output, 256, digest; A is [255:224] and H is [31:0].
REQ-010 Port out_v, output, 1, digest valid.
REQ-011 Port out_rdy, input, 1, the consumer accepts the digest.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 in_rdy SHALL be 1 in IDLE only; a block is accepted on a rising edge where in_v=1 and in_rdy=1.
REQ-014 On acceptance, the core SHALL latch M_in into a 16-word schedule window and latch the base hash: the IV if init=1 or CHAIN_EN=0, otherwise the chain register.
REQ-015 On acceptance, the core SHALL load working registers a..h from the base hash, clear the round counter and enter RUN.
REQ-016 In RUN, each edge SHALL execute RPC consecutive rounds (T1 = h+S1(e)+Ch(e,f,g)+K[t]+W[t]; T2 = S0(a)+Maj(a,b,c)), with all additions modulo 2^32.
REQ-017 In RUN, the round counter SHALL advance by RPC on each edge.
REQ-018 The schedule SHALL be generated on the fly: W[t] = s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] for t>=16; no 64-word storage is permitted.
REQ-019 After exactly 64/RPC RUN edges (64, 32 or 16), the FSM SHALL enter DONE; out_v is 1 only in DONE.
REQ-020 In DONE, H256_out SHALL equal the word-wise mod-2^32 sum of the base hash and a..h, and SHALL stay stable while out_v=1 and out_rdy=0.
REQ-021 On a DONE edge with out_rdy=1, the core SHALL copy H256_out into the chain register and enter IDLE; in_rdy rises the next cycle, and there is no same-edge re-accept.
REQ-022 in_v during RUN or DONE SHALL be ignored and SHALL NOT disturb the computation.
REQ-023 If init=0 arrives with no prior completed block since reset, the chain register (holding the IV) SHALL be used.
REQ-024 The round counter SHALL saturate at 64; it SHALL NOT wrap inside RUN.
REQ-025 K constants SHALL be combinational lookups indexed by round number; RPC lookups are needed per cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, in_rdy=1, out_v=0, round counter=0, chain register=IV, and working registers and schedule=0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the block; no digest is emitted and the chain reverts to the IV.
REQ-028 Deassertion SHALL be synchronised externally; the first acceptance can occur on the first edge after deassertion.

Structure
REQ-029 A shared package sha256_pkg SHALL hold the 64-entry K table, the 8-word IV, the state enumeration and the functions Ch, Maj, S0, S1, s0 and s1.
REQ-030 One sub-module sha256_round (a combinational single round) SHALL be instantiated RPC times in a generate chain.

Verification
REQ-031 "abc" padded block, init=1, RPC=1 -> out_v exactly 64 edges after acceptance; H256_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-032 Empty-string padded block (80000000 then zeros), RPC=4 -> out_v after 16 edges; H256_out=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-033 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", block 1 init=1, block 2 init=0, RPC=2 -> final H256_out=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-034 "abc" with out_rdy held 0 for 10 cycles after out_v -> H256_out is constant and in_rdy=0 throughout; on release, in_rdy=1 on the following cycle.
REQ-035 rst_n pulsed low at round 30 of a block, then "abc" sent with init=0 -> the "abc" digest of REQ-031 results, proving the chain reverted to the IV.
REQ-036 in_v held high with new data during RUN -> the digest is unchanged from the single-block reference value.
